ksa_share_arbiter: RTL

Round-robin arbiter that shares one 32-bit Kogge-Stone adder core (`UBPriKSA_31_0`, carry-in exposed) among `NREQ` requesters. Each requester pushes operand beats over a valid/ready handshake. A multi-beat chain locks the adder to one requester and feeds each beat's carry-out into the next beat's carry-in, so a requester can do 64-bit or wider additions. Results leave through a single registered response port tagged with the requester index. The block sits between the address/accumulate clients and the adder datapath.

---
 rtl/ksa_pkg.sv | 16 +
 rtl/UBPriKSA_31_0.sv | 40 ++++
 rtl/rr_pick.sv | 35 +++
 rtl/ksa_share_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ksa_pkg.sv
// Shared definitions for the Kogge-Stone adder sharing logic.
//   KSA_W       : operand width of the shared adder core
//   ksa_sum_t   : adder result, carry-out in the top bit
//   arb_state_e : arbitration state of the sharing front end
package ksa_pkg;

    localparam int KSA_W = 32;

    typedef logic [KSA_W:0] ksa_sum_t;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/UBPriKSA_31_0.sv
// 32-bit Kogge-Stone prefix adder core with carry-in.
//   X, Y : 32-bit unsigned operands
//   Cin  : carry into bit 0
//   S    : 33-bit result, S[32] is the carry-out
module UBPriKSA_31_0 (
    input  logic [31:0] X,
    input  logic [31:0] Y,
    input  logic        Cin,
    output logic [32:0] S
);

    // Position 0 of the prefix vectors carries Cin as a pure generate, so
    // after the prefix network g[k] is the carry into bit k.
    logic [32:0] g;
    logic [32:0] p;
    logic [32:0] gn;
    logic [32:0] pn;

    always_comb begin
        g  = {X & Y, Cin};
        p  = {X ^ Y, 1'b0};
        gn = g;
        pn = p;
        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < 33; k++) begin
                if (k >= (1 << s)) begin
                    gn[k] = g[k] | (p[k] & g[k - (1 << s)]);
                    pn[k] = p[k] & p[k - (1 << s)];
                end else begin
                    gn[k] = g[k];
                    pn[k] = p[k];
                end
            end
            g = gn;
            p = pn;
        end
        S = {g[32], (X ^ Y) ^ g[31:0]};
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : index with highest priority; priority then rotates upward
//   gnt : one-hot grant (zero when no request)
//   idx : encoded index of the granted request
//   any : at least one request present
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/ksa_share_arbiter.sv
// Shares one 32-bit Kogge-Stone adder among NREQ requesters.
//   clk, rst_n                : clock, async active-low reset
//   req_valid/req_ready       : per-requester beat handshake
//   req_x/req_y               : packed operands, requester i at [32i+31:32i]
//   req_last                  : final beat of a (possibly multi-beat) chain
//   rsp_valid/rsp_ready       : registered response handshake
//   rsp_sum/rsp_id/rsp_last   : 33-bit sum, issuing requester, last flag
//
// state | meaning
// ARB   | round-robin over all valid requesters from rr_ptr
// LOCK  | chain in progress; only lock_id may issue, carry_q feeds Cin
module ksa_share_arbiter
    import ksa_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*KSA_W-1:0] req_x,
    input  logic [NREQ*KSA_W-1:0] req_y,
    input  logic [NREQ-1:0]       req_last,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output ksa_sum_t              rsp_sum,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_last
);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           carry_q, carry_d;
    logic           rsp_valid_q, rsp_valid_d;
    ksa_sum_t       rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_last_q, rsp_last_d;

    logic [NREQ-1:0]  eligible;
    logic [IDW-1:0]   pick_ptr;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   win;
    logic             any;
    logic             can_issue;
    logic             accept;
    logic [KSA_W-1:0] x_w;
    logic [KSA_W-1:0] y_w;
    logic             last_w;
    logic             cin;
    ksa_sum_t         sum;

    // While locked, masking to lock_id and pointing at it makes the picker
    // grant the chain owner or nobody.
    always_comb begin
        eligible = req_valid;
        pick_ptr = rr_ptr_q;
        if (state_q == LOCK) begin
            eligible = req_valid & (NREQ'(1) << lock_id_q);
            pick_ptr = lock_id_q;
        end
    end

    rr_pick #(.N(NREQ), .IW(IDW)) u_rr_pick (
        .req (eligible),
        .ptr (pick_ptr),
        .gnt (gnt),
        .idx (win),
        .any (any)
    );

    assign can_issue = !rsp_valid_q || rsp_ready;
    assign req_ready = gnt & {NREQ{can_issue}};
    assign accept    = any && can_issue;
    assign cin       = (state_q == LOCK) && carry_q;

    always_comb begin
        x_w    = '0;
        y_w    = '0;
        last_w = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                x_w    = req_x[i*KSA_W +: KSA_W];
                y_w    = req_y[i*KSA_W +: KSA_W];
                last_w = req_last[i];
            end
        end
    end

    UBPriKSA_31_0 u_ksa (
        .X   (x_w),
        .Y   (y_w),
        .Cin (cin),
        .S   (sum)
    );

    always_comb begin
        state_d     = state_q;
        lock_id_d   = lock_id_q;
        rr_ptr_d    = rr_ptr_q;
        carry_d     = carry_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        rsp_last_d  = rsp_last_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_sum_d   = sum;
            rsp_id_d    = win;
            rsp_last_d  = last_w;
            carry_d     = sum[KSA_W];
            if (last_w) begin
                state_d  = ARB;
                rr_ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
            end else begin
                state_d   = LOCK;
                lock_id_d = win;
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            lock_id_q   <= '0;
            rr_ptr_q    <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_id_q   <= lock_id_d;
            rr_ptr_q    <= rr_ptr_d;
            carry_q     <= carry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_last  = rsp_last_q;

endmodule
